// File: rtl/fir_interpolator_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_interpolator_if
// Description : Sample stream bundle for the polyphase FIR interpolator.
//               Carries the low-rate input handshake (data_in / in_valid /
//               in_ready) and the high-rate output side (data_out /
//               out_valid / underrun).
//               modport slave  : the interpolator itself
//               modport master : the producer/consumer driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_interpolator_if #(
  parameter int IW = 16
);
  logic [IW-1:0] data_in;    // signed low-rate sample
  logic          in_valid;   // data_in valid
  logic          in_ready;   // interpolator can take a sample
  logic [IW-1:0] data_out;   // signed interpolated sample, held between updates
  logic          out_valid;  // one-cycle strobe for a new data_out
  logic          underrun;   // sticky: a sample was needed but not available

  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready,
    output data_out,
    output out_valid,
    output underrun
  );

  modport master (
    output data_in,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  underrun
  );
endinterface
`default_nettype wire

// File: rtl/fir_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : fir_interpolator
// Description : Polyphase FIR interpolator by PHASES. Each output period
//               (OUT_DIV clocks) one output sample is produced with a single
//               time-shared multiplier: TAPS multiply-accumulate cycles over
//               the history buffer using the coefficient branch of the
//               current phase, then round-half-up and saturate. A new input
//               sample is consumed once every PHASES outputs.
// Ports       : clk          - system clock, rising edge
//               reset        - synchronous active-high reset
//               coefficients - PHASES*TAPS signed Q1.(CW-1) coefficients,
//                              index k*PHASES+phase, static while running
//               bus          - fir_interpolator_if.slave sample stream
// Parameters  : IW, CW, PHASES, TAPS, OUT_DIV (OUT_DIV must be >= TAPS+4 so
//               that every output tick finds the FSM in IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
module fir_interpolator #(
  parameter int IW      = 16,
  parameter int CW      = 16,
  parameter int PHASES  = 4,
  parameter int TAPS    = 8,
  parameter int OUT_DIV = 1118
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PHASES*TAPS-1:0][CW-1:0]    coefficients,
  fir_interpolator_if.slave                 bus
);

  // --------------------------------------------------------------------------
  // Derived widths
  // --------------------------------------------------------------------------
  // Accumulator: worst case is TAPS full-scale products, so $clog2(TAPS)
  // guard bits above the IW+CW product width rule out internal overflow.
  localparam int c_acc_w = IW + CW + $clog2(TAPS);
  localparam int c_kw    = (TAPS > 1)          ? $clog2(TAPS)          : 1;
  localparam int c_pw    = (PHASES > 1)        ? $clog2(PHASES)        : 1;
  localparam int c_dw    = (OUT_DIV > 1)       ? $clog2(OUT_DIV)       : 1;
  localparam int c_ciw   = (PHASES * TAPS > 1) ? $clog2(PHASES * TAPS) : 1;

  localparam logic [c_kw-1:0] c_k_last     = c_kw'(TAPS - 1);
  localparam logic [c_pw-1:0] c_phase_last = c_pw'(PHASES - 1);
  localparam logic [c_dw-1:0] c_div_last   = c_dw'(OUT_DIV - 1);

  // 2^(CW-2): one half LSB of the Q1.(CW-1) product scaling
  localparam logic signed [c_acc_w-1:0] c_round_half =
    {{(c_acc_w - CW + 1){1'b0}}, 1'b1, {(CW - 2){1'b0}}};

  localparam logic [IW-1:0] c_sat_max = {1'b0, {(IW - 1){1'b1}}};
  localparam logic [IW-1:0] c_sat_min = {1'b1, {(IW - 1){1'b0}}};

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_dw-1:0]           r_div;
  logic                      r_tick;
  logic [c_kw-1:0]           r_k;
  logic [c_pw-1:0]           r_phase;
  logic signed [c_acc_w-1:0] r_acc;
  logic signed [IW-1:0]      r_x [TAPS];
  logic [IW-1:0]             r_hold;
  logic                      r_hold_full;
  logic [IW-1:0]             r_data_out;
  logic                      r_out_valid;
  logic                      r_underrun;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                          w_shift;
  logic [IW-1:0]                 w_shift_in;
  logic [c_ciw-1:0]              w_coef_idx;
  logic signed [CW-1:0]          w_coef;
  logic signed [IW-1:0]          w_xk;
  logic signed [IW+CW-1:0]       w_prod;
  logic signed [c_acc_w-1:0]     w_prod_ext;
  logic signed [c_acc_w-1:0]     w_rnd;
  logic signed [c_acc_w-1:0]     w_shr;
  logic [c_acc_w-IW:0]           w_hi;
  logic                          w_fits;
  logic [IW-1:0]                 w_y;

  // --------------------------------------------------------------------------
  // Output-rate divider. The tick is registered so that it appears exactly
  // OUT_DIV cycles after reset release and every OUT_DIV cycles thereafter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == c_div_last);
      if (r_div == c_div_last) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A tick seen outside IDLE is simply ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_tick) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_MAC;
      S_MAC:   if (r_k == c_k_last) w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Input side. The history only advances at the start of phase 0. At that
  // moment the held sample (if any) is consumed, and the port stays ready so
  // a sample offered in the same cycle either refills the hold register or,
  // with the hold empty, goes straight into the history.
  // --------------------------------------------------------------------------
  assign w_shift = (r_state == S_LOAD) && (r_phase == '0);

  always_comb begin
    w_shift_in = '0;
    if (r_hold_full) begin
      w_shift_in = r_hold;
    end else if (bus.in_valid) begin
      w_shift_in = bus.data_in;
    end
  end

  assign bus.in_ready = !r_hold_full || w_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
      end
    end else begin
      if (w_shift) begin
        r_x[0] <= $signed(w_shift_in);
        for (int i = 1; i < TAPS; i++) begin
          r_x[i] <= r_x[i-1];
        end

        if (r_hold_full) begin
          if (bus.in_valid) begin
            r_hold <= bus.data_in;
          end else begin
            r_hold_full <= 1'b0;
          end
        end else if (!bus.in_valid) begin
          // Nothing to consume: a zero went into the history instead.
          r_underrun <= 1'b1;
        end
      end else if (bus.in_valid && !r_hold_full) begin
        r_hold      <= bus.data_in;
        r_hold_full <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Multiply-accumulate datapath: tap k of the current phase branch.
  // --------------------------------------------------------------------------
  assign w_coef_idx = c_ciw'(r_k) * c_ciw'(PHASES) + c_ciw'(r_phase);
  assign w_coef     = $signed(coefficients[w_coef_idx]);
  assign w_xk       = r_x[r_k];
  assign w_prod     = w_xk * w_coef;
  assign w_prod_ext = c_acc_w'(w_prod);

  // --------------------------------------------------------------------------
  // Round half up back to Q1.(IW-1), then saturate: the result fits in IW
  // bits only when every bit from the IW-1 position upward equals the sign.
  // --------------------------------------------------------------------------
  assign w_rnd  = r_acc + c_round_half;
  assign w_shr  = w_rnd >>> (CW - 1);
  assign w_hi   = w_shr[c_acc_w-1:IW-1];
  assign w_fits = (&w_hi) || !(|w_hi);

  always_comb begin
    w_y = w_shr[IW-1:0];
    if (!w_fits) begin
      w_y = w_shr[c_acc_w-1] ? c_sat_min : c_sat_max;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator, tap counter, phase and output registers. data_out and the
  // out_valid strobe are loaded together at the end of ROUND, so out_valid
  // is high for exactly the OUT cycle with the new data_out alongside it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_k         <= '0;
      r_phase     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == S_ROUND);
      case (r_state)
        S_LOAD: begin
          r_acc <= '0;
          r_k   <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + 1'b1;
        end
        S_ROUND: begin
          r_data_out <= w_y;
        end
        S_OUT: begin
          if (r_phase == c_phase_last) begin
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;
  assign bus.underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_interpolator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_interpolator
// Description : Self-checking bench for fir_interpolator with IW=16, CW=16,
//               PHASES=4, TAPS=8, OUT_DIV=16. Expected outputs are queued
//               when stimulus is applied and compared in order as out_valid
//               strobes arrive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_interpolator;

  localparam int IW      = 16;
  localparam int CW      = 16;
  localparam int PHASES  = 4;
  localparam int TAPS    = 8;
  localparam int OUT_DIV = 16;
  localparam int FIRST_OUT = OUT_DIV + TAPS + 3;

  logic clk = 1'b0;
  logic reset;
  logic [PHASES*TAPS-1:0][CW-1:0] coefficients;

  fir_interpolator_if #(.IW(IW)) bus ();

  fir_interpolator #(
    .IW(IW), .CW(CW), .PHASES(PHASES), .TAPS(TAPS), .OUT_DIV(OUT_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coefficients(coefficients),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] coef;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t vecs[11];

  // backpressure test shared state
  bit bp_done;
  int acc_cnt;
  int bp_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_coef_all(input logic [15:0] c);
    for (int i = 0; i < PHASES*TAPS; i++) coefficients[i] = c;
  endtask

  // only tap 0 of every phase branch is non-zero: output = round(c * x[0])
  task automatic set_coef_tap0(input logic [15:0] c);
    for (int i = 0; i < PHASES*TAPS; i++) coefficients[i] = (i < PHASES) ? c : 16'h0000;
  endtask

  // Holds reset for 3 edges, checks reset values, releases reset #1 after
  // the last reset edge (so the caller sits in cycle 0 after release).
  task automatic do_reset(input string name);
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_rst_data_out"},  32'(bus.data_out),  32'h0);
    check({name, "_rst_out_valid"}, 32'(bus.out_valid), 32'h0);
    check({name, "_rst_underrun"},  32'(bus.underrun),  32'h0);
    check({name, "_rst_in_ready"},  32'(bus.in_ready),  32'h1);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits for skip+n output strobes; the last n are compared with the queue.
  task automatic collect(input int skip, input int n, input string name);
    bit ok;
    logic [15:0] e;
    for (int i = 0; i < skip + n; i++) begin
      wait_out(ok);
      if (!ok) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_timeout: no out_valid within 64 cycles (output %0d)", name, i);
        return;
      end
      if (i >= skip) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s_empty: output %0d=%h with no expected value queued", name, i, bus.data_out);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_out%0d", name, i), 32'(bus.data_out), 32'(e));
        end
      end
    end
  endtask

  // counts edges from cycle 0 to the first out_valid
  task automatic measure_latency(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) break;
    end
    check(name, 32'(n), 32'(FIRST_OUT));
  endtask

  function automatic logic [15:0] bp_sample(input int i);
    return 16'(i * 4099 - 20000);
  endfunction

  // x * 0.5 with round half up: floor((x+1)/2)
  function automatic logic [15:0] bp_expect(input int i);
    int xi;
    xi = int'($signed(bp_sample(i)));
    return 16'((xi + 1) >>> 1);
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;

    vecs[0]  = '{16'h4000, 16'h4000, 16'h2000};
    vecs[1]  = '{16'h4000, 16'h0001, 16'h0001};
    vecs[2]  = '{16'h4000, 16'hFFFF, 16'h0000};
    vecs[3]  = '{16'h4000, 16'hFFFD, 16'hFFFF};
    vecs[4]  = '{16'h7FFF, 16'h7FFF, 16'h7FFE};
    vecs[5]  = '{16'h8000, 16'h8000, 16'h7FFF};
    vecs[6]  = '{16'h8000, 16'h7FFF, 16'h8001};
    vecs[7]  = '{16'h2000, 16'h0003, 16'h0001};
    vecs[8]  = '{16'h2000, 16'h0002, 16'h0001};
    vecs[9]  = '{16'h2000, 16'hFFFE, 16'h0000};
    vecs[10] = '{16'h4000, 16'h8000, 16'hC000};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    set_coef_all(16'h0000);

    // ---- reset values and first-output latency
    do_reset("lat");
    measure_latency("latency_first_out");

    // ---- reset mid-MAC: LOAD is cycle 17, reset asserted in cycle 20
    do_reset("midmac_a");
    repeat (20) @(posedge clk);
    #1;
    check("midmac_no_early_out", 32'(bus.out_valid), 32'h0);
    do_reset("midmac_b");
    measure_latency("midmac_latency");

    // ---- table: single-tap rounding and saturation
    for (int v = 0; v < 11; v++) begin
      set_coef_tap0(vecs[v].coef);
      do_reset($sformatf("vec%0d", v));
      bus.in_valid = 1'b1;
      bus.data_in  = vecs[v].x;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.data_in  = '0;
      for (int r = 0; r < PHASES; r++) exp_q.push_back(vecs[v].y);
      collect(0, PHASES, $sformatf("vec%0d", v));
    end

    // ---- impulse through all taps
    set_coef_all(16'h4000);
    do_reset("imp");
    bus.in_valid = 1'b1;
    bus.data_in  = 16'h4000;
    @(posedge clk);
    #1;
    bus.data_in = 16'h0000;
    for (int i = 0; i < PHASES*TAPS; i++) exp_q.push_back(16'h2000);
    for (int i = 0; i < PHASES; i++) exp_q.push_back(16'h0000);
    collect(0, PHASES*TAPS + PHASES, "impulse");
    check("impulse_underrun", 32'(bus.underrun), 32'h0);
    bus.in_valid = 1'b0;

    // ---- positive saturation
    set_coef_all(16'h7FFF);
    do_reset("satp");
    bus.in_valid = 1'b1;
    bus.data_in  = 16'h7FFF;
    exp_q.push_back(16'h7FFE);
    collect(0, 1, "satp_first");
    for (int i = 0; i < PHASES; i++) exp_q.push_back(16'h7FFF);
    collect(PHASES*TAPS - PHASES - 1, PHASES, "satp_full");
    bus.in_valid = 1'b0;

    // ---- negative saturation
    do_reset("satn");
    bus.in_valid = 1'b1;
    bus.data_in  = 16'h8000;
    exp_q.push_back(16'h8001);
    collect(0, 1, "satn_first");
    for (int i = 0; i < PHASES; i++) exp_q.push_back(16'h8000);
    collect(PHASES*TAPS - PHASES - 1, PHASES, "satn_full");
    bus.in_valid = 1'b0;

    // ---- underrun: no input at the first phase-0 load, then a late sample
    set_coef_tap0(16'h4000);
    do_reset("und");
    for (int i = 0; i < PHASES; i++) exp_q.push_back(16'h0000);
    collect(0, PHASES, "und_zero");
    check("und_set", 32'(bus.underrun), 32'h1);
    bus.in_valid = 1'b1;
    bus.data_in  = 16'h1000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    for (int i = 0; i < PHASES; i++) exp_q.push_back(16'h0800);
    collect(0, PHASES, "und_late");
    check("und_sticky", 32'(bus.underrun), 32'h1);

    // ---- backpressure: in_valid always high, one accept per PHASES outputs
    set_coef_tap0(16'h4000);
    do_reset("bp");
    bp_done = 1'b0;
    acc_cnt = 0;
    bp_idx  = 0;
    bus.data_in  = bp_sample(0);
    bus.in_valid = 1'b1;
    fork
      begin : bp_driver
        logic took;
        while (!bp_done) begin
          @(negedge clk);
          took = bus.in_valid && bus.in_ready;
          @(posedge clk);
          if (took) begin
            for (int r = 0; r < PHASES; r++) exp_q.push_back(bp_expect(bp_idx));
            acc_cnt++;
            bp_idx++;
            #1;
            bus.data_in = bp_sample(bp_idx);
          end
        end
      end
      begin : bp_collector
        collect(0, 10*PHASES, "bp");
        check("bp_accepts", 32'(acc_cnt), 32'd11);
        check("bp_underrun", 32'(bus.underrun), 32'h0);
        bp_done = 1'b1;
      end
    join
    bus.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_interpolator.md
FIR_INTERPOLATOR -- requirements
Module: fir_interpolator

Interface
REQ-001 Parameter IW, default 16: signed sample width, input and output.
REQ-002 Parameter CW, default 16: signed coefficient width, Q1.(CW-1) format.
REQ-003 Parameter PHASES, default 4: interpolation factor (output samples per input sample).
REQ-004 Parameter TAPS, default 8: taps per polyphase branch; total coefficients PHASES*TAPS.
REQ-005 Parameter OUT_DIV, default 1118: clk cycles per output sample; legal only if OUT_DIV >= TAPS+4.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 coefficients  input  [CW-1:0] x PHASES*TAPS  signed coefficients, static during operation.
REQ-009 data_in  input  IW  signed low-rate input sample.
REQ-010 in_valid  input  1  data_in valid; transfer when in_valid && in_ready.
REQ-011 in_ready  output  1  holding register can accept a sample.
REQ-012 data_out  output  IW  signed interpolated output sample, held between updates.
REQ-013 out_valid  output  1  one-cycle strobe marking a new data_out.
REQ-014 underrun  output  1  sticky flag: input sample was required but unavailable.

Function
REQ-015 Output-rate divider counts 0..OUT_DIV-1 and pulses internal tick for one cycle per wrap; first tick occurs OUT_DIV cycles after reset deasserts.
REQ-016 One-entry holding register; in_ready = !hold_full, or in LOAD with phase==0 (bypass case of REQ-019).
REQ-017 FSM states: IDLE, LOAD, MAC, ROUND, OUT; IDLE->LOAD on tick; LOAD->MAC; MAC->ROUND after TAPS cycles; ROUND->OUT; OUT->IDLE.
REQ-018 History buffer x[0..TAPS-1] of signed samples; shifts (x[k] <= x[k-1], x[0] <= new) only in LOAD when phase==0.
REQ-019 In LOAD with phase==0: hold_full -> shift hold in, clear hold; else in_valid -> shift data_in directly (accepted this cycle); else shift 0 and set underrun.
REQ-020 MAC: one signed multiply per cycle, acc += x[k]*coefficients[k*PHASES+phase], k=0..TAPS-1; acc cleared in LOAD.
REQ-021 Accumulator width IW+CW+$clog2(TAPS), no internal overflow.
REQ-022 ROUND: y = (acc + 2^(CW-2)) >>> (CW-1), arithmetic shift, round half up; saturate to [-2^(IW-1), 2^(IW-1)-1].
REQ-023 OUT: data_out <= y, out_valid high exactly this cycle; phase increments, wrapping PHASES-1 -> 0.
REQ-024 Latency: tick in cycle t -> out_valid in cycle t+TAPS+3.
REQ-025 A tick arriving outside IDLE is dropped (cannot occur for legal OUT_DIV).
REQ-026 underrun stays set until reset; filter continues operating.
REQ-027 Samples presented while hold_full are not accepted; no data loss under valid/ready protocol.

Reset
REQ-028 On reset: data_out=0, out_valid=0, underrun=0, in_ready=1, x[]=0, acc=0, hold empty, phase=0, divider=0, FSM=IDLE.
REQ-029 Reset in any state (including mid-MAC) takes effect next edge; no out_valid produced for the aborted computation.

Verification (IW=16, CW=16, PHASES=4, TAPS=8, OUT_DIV=16)
REQ-030 Reset: hold reset 3 cycles -> all outputs per REQ-028; first out_valid at cycle 16+11 after release.
REQ-031 Impulse: all coefficients 0x4000, one sample 0x4000 then zeros -> 32 consecutive outputs 0x2000, then 0x0000; underrun stays 0.
REQ-032 Saturation: all coefficients 0x7FFF, inputs continuously 0x7FFF -> data_out 0x7FFF once buffer full; inputs 0x8000 -> 0x8000.
REQ-033 Underrun: in_valid low at a phase-0 LOAD -> zero shifted in, underrun=1 and remains 1 after later valid inputs until reset.
REQ-034 Backpressure: in_valid held high -> exactly one sample accepted per 4 out_valid pulses, in order, no drops or duplicates.
REQ-035 Reset mid-MAC: assert reset 3 cycles after LOAD -> no out_valid, state per REQ-028, next result follows REQ-030 timing.
